// File: rtl/fifo_push_arbiter_if.sv
// fifo_push_arbiter_if: requester and FIFO write-side signals of the push arbiter
interface fifo_push_arbiter_if #(
  parameter int N_REQ      = 4,
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8,
  parameter int MULTI_POP  = 1
);
  logic [N_REQ-1:0]                 req_valid;
  logic [N_REQ-1:0][DATA_WIDTH-1:0] req_data;
  logic [N_REQ-1:0]                 req_last;
  logic [N_REQ-1:0]                 req_ready;
  logic                             fifo_push;
  logic [DATA_WIDTH-1:0]            fifo_data;
  logic [$clog2(MULTI_POP):0]       poll_cnt;
  logic [$clog2(DEPTH):0]           occupancy;
  logic                             locked;
  logic [$clog2(N_REQ)-1:0]         owner;
  modport master (
    output req_valid, req_data, req_last, poll_cnt,
    input  req_ready, fifo_push, fifo_data, occupancy, locked, owner
  );
  modport slave (
    input  req_valid, req_data, req_last, poll_cnt,
    output req_ready, fifo_push, fifo_data, occupancy, locked, owner
  );
endinterface

// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter: round-robin, packet-locking arbiter for a shared FIFO push port
module fifo_push_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8,
  parameter int MULTI_POP  = 1
) (
  input logic                clk,
  input logic                rst,
  fifo_push_arbiter_if.slave bus
);
  localparam int IW = $clog2(N_REQ);
  localparam int OW = $clog2(DEPTH) + 1;
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t        state_q;
  logic [IW-1:0] rr_q, owner_q, gnt, sel, nxt;
  logic [IW:0]   w;
  logic [OW-1:0] occ_q, occ_d;
  logic [OW:0]   sum, pol;
  logic          space;
  // Descending scan so the last hit is the first valid requester at or after rr_q
  always_comb begin
    gnt = rr_q;
    w = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w = (IW+1)'(rr_q) + (IW+1)'(k);
      w = w >= (IW+1)'(N_REQ) ? w - (IW+1)'(N_REQ) : w;
      if (bus.req_valid[w[IW-1:0]]) gnt = w[IW-1:0];
    end
  end
  assign sel           = state_q == LOCKED ? owner_q : gnt;
  assign nxt           = sel == IW'(N_REQ - 1) ? '0 : sel + IW'(1);
  assign space         = occ_q < OW'(DEPTH - 1);
  assign bus.req_ready = (!rst && space && bus.req_valid[sel]) ? N_REQ'(1) << sel : '0;
  assign bus.fifo_push = |bus.req_ready;
  assign bus.fifo_data = bus.req_data[sel];
  assign bus.occupancy = occ_q;
  assign bus.locked    = state_q == LOCKED;
  assign bus.owner     = owner_q;
  // An illegal over-pop clamps to empty rather than wrapping
  assign sum   = {1'b0, occ_q} + (OW+1)'(bus.fifo_push);
  assign pol   = (OW+1)'(bus.poll_cnt);
  assign occ_d = pol > {1'b0, occ_q} ? '0 : OW'(sum - pol);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      owner_q <= '0;
      occ_q   <= '0;
    end else begin
      occ_q <= occ_d;
      if (bus.fifo_push) begin
        owner_q <= sel;
        state_q <= bus.req_last[sel] ? IDLE : LOCKED;
        if (bus.req_last[sel]) rr_q <= nxt;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (pol <= {1'b0, occ_q});
      assert (occ_q <= OW'(DEPTH - 1));
    end
  end
endmodule

// File: tb/tb_fifo_push_arbiter.sv
// tb_fifo_push_arbiter: directed and random checks against a behavioural arbiter model
module tb_fifo_push_arbiter;
  localparam int N = 4, D = 8, W = 8, MP = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  fifo_push_arbiter_if #(.N_REQ(N), .DEPTH(D), .DATA_WIDTH(W), .MULTI_POP(MP)) bus ();
  fifo_push_arbiter #(.N_REQ(N), .DEPTH(D), .DATA_WIDTH(W), .MULTI_POP(MP)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  int checks = 0, errors = 0;
  int m_occ = 0, m_rr = 0, m_own = 0, m_sel = -1;
  bit m_lock = 1'b0;
  logic [N-1:0] exp_rdy;
  int gs [7] = '{0, 1, 2, 3, 0, 1, 2};
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] l, input int p);
    bus.req_valid = v;
    bus.req_last  = l;
    bus.poll_cnt  = 2'(p);
    for (int i = 0; i < N; i++) bus.req_data[i] = W'($urandom);
  endtask
  task automatic settle;
    #1;
    m_sel   = -1;
    exp_rdy = '0;
    if (!rst && m_occ < D - 1) begin
      if (m_lock) begin
        if (bus.req_valid[m_own]) m_sel = m_own;
      end else begin
        for (int k = 0; k < N; k++)
          if (m_sel < 0 && bus.req_valid[(m_rr + k) % N]) m_sel = (m_rr + k) % N;
      end
    end
    if (m_sel >= 0) exp_rdy = N'(1) << m_sel;
    chk("req_ready", bus.req_ready, exp_rdy);
    chk("fifo_push", bus.fifo_push, m_sel >= 0);
    if (m_sel >= 0) chk("fifo_data", bus.fifo_data, bus.req_data[m_sel]);
    chk("occupancy", bus.occupancy, m_occ);
    chk("locked", bus.locked, m_lock);
    chk("owner", bus.owner, m_own);
  endtask
  task automatic tick;
    @(posedge clk);
    if (rst) begin
      m_occ  = 0;
      m_rr   = 0;
      m_own  = 0;
      m_lock = 1'b0;
    end else begin
      if (m_sel >= 0) begin
        m_own = m_sel;
        if (bus.req_last[m_sel]) begin
          m_lock = 1'b0;
          m_rr   = (m_sel + 1) % N;
        end else m_lock = 1'b1;
      end
      m_occ = m_occ + (m_sel >= 0 ? 1 : 0) - int'(bus.poll_cnt);
    end
    @(negedge clk);
  endtask
  task automatic cyc;
    settle();
    tick();
  endtask
  initial begin
    drive(4'hF, 4'hF, 0);
    @(posedge clk);
    @(negedge clk);
    settle();
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_push", bus.fifo_push, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      settle();
      chk("rr_grant", bus.req_ready, N'(1) << gs[i]);
      tick();
    end
    settle();
    chk("full_ready", bus.req_ready, 0);
    chk("full_occ", bus.occupancy, 7);
    tick();
    drive(4'h0, 4'hF, 2);
    repeat (3) cyc();
    drive(4'h0, 4'hF, 1);
    cyc();
    rst = 1'b1;
    drive(4'h0, 4'hF, 0);
    cyc();
    rst = 1'b0;
    drive(4'b0001, 4'hF, 0);
    cyc();
    drive(4'b0111, 4'b1101, 0);
    settle();
    chk("pkt_beat1", bus.req_ready, 4'b0010);
    tick();
    drive(4'b0111, 4'b1101, 0);
    settle();
    chk("pkt_beat2", bus.req_ready, 4'b0010);
    chk("pkt_lock2", bus.locked, 1);
    tick();
    drive(4'b0111, 4'b1111, 0);
    settle();
    chk("pkt_beat3", bus.req_ready, 4'b0010);
    chk("pkt_lock3", bus.locked, 1);
    tick();
    settle();
    chk("pkt_next", bus.req_ready, 4'b0100);
    tick();
    drive(4'b0001, 4'hF, 0);
    repeat (2) cyc();
    drive(4'b0001, 4'hF, 1);
    settle();
    chk("pop_noready", bus.req_ready, 0);
    chk("pop_occ", bus.occupancy, 7);
    tick();
    drive(4'b0001, 4'hF, 0);
    settle();
    chk("pop_push", bus.req_ready, 4'b0001);
    tick();
    drive(4'h0, 4'hF, 2);
    settle();
    chk("pop_after", bus.occupancy, 7);
    tick();
    cyc();
    drive(4'b0001, 4'hF, 2);
    settle();
    chk("mp_push", bus.fifo_push, 1);
    chk("mp_occ3", bus.occupancy, 3);
    tick();
    drive(4'h0, 4'hF, 0);
    settle();
    chk("mp_occ2", bus.occupancy, 2);
    tick();
    drive(4'b1000, 4'b0000, 0);
    repeat (2) cyc();
    rst = 1'b1;
    drive(4'hF, 4'h0, 0);
    settle();
    chk("midrst_ready", bus.req_ready, 0);
    chk("midrst_push", bus.fifo_push, 0);
    tick();
    rst = 1'b0;
    drive(4'hF, 4'hF, 0);
    settle();
    chk("postrst_lock", bus.locked, 0);
    chk("postrst_occ", bus.occupancy, 0);
    chk("postrst_grant", bus.req_ready, 4'b0001);
    tick();
    drive(4'b0100, 4'b0000, 0);
    cyc();
    repeat (5) begin
      drive(4'b1011, 4'hF, 0);
      settle();
      chk("bubble_ready", bus.req_ready, 0);
      chk("bubble_lock", bus.locked, 1);
      tick();
    end
    drive(4'hF, 4'hF, 0);
    settle();
    chk("bubble_resume", bus.req_ready, 4'b0100);
    tick();
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] l;
      rst = $urandom_range(0, 63) == 0;
      for (int j = 0; j < N; j++) l[j] = $urandom_range(0, 2) != 0;
      drive(N'($urandom), l, $urandom_range(0, m_occ < 2 ? m_occ : 2));
      cyc();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
